dual_grant_decoder: RTL and testbench

Decodes the index pair produced by the dual priority encoder (highest and second-highest active request among 12) back into one-hot grant strobes, serving them one at a time under a grant/acknowledge handshake. It sits between the request-encoding stage and the 12 requesters: it accepts one encoded pair via valid/ready, grants the first (higher-priority) index until acknowledged or timed out, then the second, then signals completion.

---
 rtl/dual_grant_decoder.sv | 177 +++++++++++++++++
 tb/tb_dual_grant_decoder.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dual_grant_decoder.sv
// Turns a captured (first, second) priority-index pair into one-hot grant strobes,
// served one at a time under a grant/acknowledge handshake with an optional hold timeout.
`timescale 1ns/1ps

module dual_grant_decoder #(
   parameter int N_REQ   = 12,
   parameter int IDX_W   = 4,
   parameter int TIMEOUT = 15
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [IDX_W-1:0] first,
   input  logic             first_vld,
   input  logic [IDX_W-1:0] second,
   input  logic             second_vld,
   output logic [N_REQ-1:0] gnt,
   output logic [IDX_W-1:0] gnt_idx,
   input  logic             gnt_ack,
   output logic             done,
   output logic             timeout,
   output logic             err
);

   localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_G1   = 2'd1,
      ST_G2   = 2'd2,
      ST_FIN  = 2'd3
   } state_t;

   state_t             state_q, state_d;
   logic [IDX_W-1:0]   first_q, first_d;
   logic [IDX_W-1:0]   second_q, second_d;
   logic               first_keep_q, first_keep_d;
   logic               second_keep_q, second_keep_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic               in_ready_q, in_ready_d;
   logic [N_REQ-1:0]   gnt_q, gnt_d;
   logic [IDX_W-1:0]   gnt_idx_q, gnt_idx_d;
   logic               done_q, done_d;
   logic               timeout_q, timeout_d;
   logic               err_q, err_d;

   logic               first_ok;
   logic               second_ok;
   logic               cap_err;
   logic               hold_expire;
   logic               hold_exit;
   logic               grant_on_d;

   // Sanitise the incoming pair: second must rank strictly below a kept first.
   assign first_ok  = first_vld && (int'(first) < N_REQ);
   assign second_ok = second_vld && first_ok && (int'(second) < N_REQ) && (second < first);
   assign cap_err   = (first_vld && !first_ok) || (second_vld && !second_ok);

   assign hold_expire = (TIMEOUT != 0) && (cnt_q == CNT_LAST);
   assign hold_exit   = gnt_ack || hold_expire;

   always_comb begin
      state_d       = state_q;
      first_d       = first_q;
      second_d      = second_q;
      first_keep_d  = first_keep_q;
      second_keep_d = second_keep_q;
      cnt_d         = cnt_q;
      err_d         = 1'b0;
      timeout_d     = 1'b0;

      unique case (state_q)
         ST_IDLE: begin
            if (in_valid && in_ready_q) begin
               first_d       = first;
               second_d      = second;
               first_keep_d  = first_ok;
               second_keep_d = second_ok;
               err_d         = cap_err;
               cnt_d         = '0;
               // A pair with no usable first still spends one silent cycle in G1,
               // so err and done land in separate cycles.
               state_d       = ST_G1;
            end
         end
         ST_G1: begin
            if (!first_keep_q) begin
               state_d = ST_FIN;
            end else if (hold_exit) begin
               cnt_d     = '0;
               timeout_d = !gnt_ack;
               state_d   = second_keep_q ? ST_G2 : ST_FIN;
            end else if (TIMEOUT != 0) begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         ST_G2: begin
            if (hold_exit) begin
               cnt_d     = '0;
               timeout_d = !gnt_ack;
               state_d   = ST_FIN;
            end else if (TIMEOUT != 0) begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         ST_FIN: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // Outputs are precomputed from the next state so they come straight off flops.
   always_comb begin
      in_ready_d = (state_d == ST_IDLE);
      done_d     = (state_d == ST_FIN);
      grant_on_d = ((state_d == ST_G1) && first_keep_d) || (state_d == ST_G2);
      gnt_idx_d  = '0;
      if (state_d == ST_G1 && first_keep_d) begin
         gnt_idx_d = first_d;
      end else if (state_d == ST_G2) begin
         gnt_idx_d = second_d;
      end
   end

   genvar gi;
   generate
      for (gi = 0; gi < N_REQ; gi++) begin : g_onehot
         assign gnt_d[gi] = grant_on_d && (gnt_idx_d == IDX_W'(gi));
      end
   endgenerate

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q       <= ST_IDLE;
         first_q       <= '0;
         second_q      <= '0;
         first_keep_q  <= 1'b0;
         second_keep_q <= 1'b0;
         cnt_q         <= '0;
         in_ready_q    <= 1'b1;
         gnt_q         <= '0;
         gnt_idx_q     <= '0;
         done_q        <= 1'b0;
         timeout_q     <= 1'b0;
         err_q         <= 1'b0;
      end else begin
         state_q       <= state_d;
         first_q       <= first_d;
         second_q      <= second_d;
         first_keep_q  <= first_keep_d;
         second_keep_q <= second_keep_d;
         cnt_q         <= cnt_d;
         in_ready_q    <= in_ready_d;
         gnt_q         <= gnt_d;
         gnt_idx_q     <= gnt_idx_d;
         done_q        <= done_d;
         timeout_q     <= timeout_d;
         err_q         <= err_d;
      end
   end

   assign in_ready = in_ready_q;
   assign gnt      = gnt_q;
   assign gnt_idx  = gnt_idx_q;
   assign done     = done_q;
   assign timeout  = timeout_q;
   assign err      = err_q;

   a_gnt_onehot0: assert property (@(posedge clk) disable iff (!reset_n) $onehot0(gnt_q));
   a_idle_quiet:  assert property (@(posedge clk) disable iff (!reset_n) in_ready_q |-> (gnt_q == '0));

endmodule

// File: tb/tb_dual_grant_decoder.sv
// Scoreboard bench for dual_grant_decoder: stimulus queues expected output cycles,
// a forked monitor pops and compares every cycle the DUT shows any output activity.
`timescale 1ns/1ps

module tb_dual_grant_decoder;
   localparam int N_REQ   = 12;
   localparam int IDX_W   = 4;
   localparam int TIMEOUT = 15;

   logic             clk = 1'b0;
   logic             reset_n;
   logic             in_valid;
   logic             in_ready;
   logic [IDX_W-1:0] first;
   logic             first_vld;
   logic [IDX_W-1:0] second;
   logic             second_vld;
   logic [N_REQ-1:0] gnt;
   logic [IDX_W-1:0] gnt_idx;
   logic             gnt_ack;
   logic             done;
   logic             timeout;
   logic             err;

   dual_grant_decoder #(.N_REQ(N_REQ), .IDX_W(IDX_W), .TIMEOUT(TIMEOUT)) dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .first      (first),
      .first_vld  (first_vld),
      .second     (second),
      .second_vld (second_vld),
      .gnt        (gnt),
      .gnt_idx    (gnt_idx),
      .gnt_ack    (gnt_ack),
      .done       (done),
      .timeout    (timeout),
      .err        (err)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [N_REQ-1:0] gnt;
      logic [IDX_W-1:0] idx;
      logic             done;
      logic             to;
      logic             err;
   } ev_t;

   ev_t              exp_q[$];
   int               n_tests = 0;
   int               n_fail  = 0;
   int               ack_wait = 0;   // grant cycles before ack; -1 = never ack
   logic [N_REQ-1:0] last_gnt = '0;
   int               hold = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      n_tests++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got %0h, required %0h", name, act, req);
      end
   endtask

   task automatic push_ev(input int idx, input bit has_gnt, input bit d, input bit t, input bit e);
      ev_t ev;
      ev.gnt  = has_gnt ? (N_REQ'(1) << idx) : '0;
      ev.idx  = has_gnt ? IDX_W'(idx) : '0;
      ev.done = d;
      ev.to   = t;
      ev.err  = e;
      exp_q.push_back(ev);
   endtask

   task automatic push_grant(input int idx, input int n, input bit first_to, input bit first_err);
      for (int i = 0; i < n; i++) begin
         push_ev(idx, 1'b1, 1'b0, (i == 0) ? first_to : 1'b0, (i == 0) ? first_err : 1'b0);
      end
   endtask

   task automatic send(input int f, input bit fv, input int s, input bit sv, input bit keep_valid);
      int budget;
      first      = IDX_W'(f);
      first_vld  = fv;
      second     = IDX_W'(s);
      second_vld = sv;
      in_valid   = 1'b1;
      budget     = 200;
      while (!in_ready && budget > 0) begin
         @(negedge clk);
         budget--;
      end
      if (budget == 0) begin
         n_tests++;
         n_fail++;
         $display("FAIL send_wait_ready: got in_ready=0 for 200 cycles, required 1");
      end
      @(posedge clk);
      #1;
      if (!keep_valid) in_valid = 1'b0;
   endtask

   task automatic drain(input string name, input int budget);
      int b;
      b = budget;
      while (exp_q.size() != 0 && b > 0) begin
         @(negedge clk);
         #1;
         b--;
      end
      check({"drain_", name}, exp_q.size(), 0);
      exp_q.delete();
   endtask

   initial begin
      reset_n    = 1'b0;
      in_valid   = 1'b0;
      first      = '0;
      first_vld  = 1'b0;
      second     = '0;
      second_vld = 1'b0;
      gnt_ack    = 1'b0;

      fork
         // Monitor: every cycle with any output activity must match the queue head.
         forever begin
            ev_t act;
            ev_t req;
            @(negedge clk);
            if (reset_n === 1'b1 && (gnt != '0 || gnt_idx != '0 || done || timeout || err)) begin
               act.gnt  = gnt;
               act.idx  = gnt_idx;
               act.done = done;
               act.to   = timeout;
               act.err  = err;
               n_tests++;
               if (exp_q.size() == 0) begin
                  n_fail++;
                  $display("FAIL monitor_unexpected: got gnt=%h idx=%0d done=%b to=%b err=%b, required no activity",
                           act.gnt, act.idx, act.done, act.to, act.err);
               end else begin
                  req = exp_q.pop_front();
                  if (act !== req) begin
                     n_fail++;
                     $display("FAIL monitor_event: got gnt=%h idx=%0d done=%b to=%b err=%b, required gnt=%h idx=%0d done=%b to=%b err=%b",
                              act.gnt, act.idx, act.done, act.to, act.err,
                              req.gnt, req.idx, req.done, req.to, req.err);
                  end
               end
            end
         end
         // Requester model: acks after ack_wait cycles of the same grant.
         forever begin
            @(negedge clk);
            if (gnt == '0) begin
               hold    = 0;
               gnt_ack = 1'b0;
            end else begin
               if (gnt != last_gnt) hold = 0;
               gnt_ack = (ack_wait >= 0) && (hold >= ack_wait);
               hold++;
            end
            last_gnt = gnt;
         end
         begin
            #200000;
            $display("FAIL watchdog: got no finish by 200us, required completion");
            $fatal(1, "watchdog");
         end
      join_none

      // Reset values
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("rst_in_ready", in_ready, 1);
      check("rst_gnt", gnt, 0);
      check("rst_gnt_idx", gnt_idx, 0);
      check("rst_done", done, 0);
      check("rst_timeout", timeout, 0);
      check("rst_err", err, 0);
      reset_n = 1'b1;
      @(negedge clk);

      // Two grants acked immediately, then in_ready returns in cycle 4
      ack_wait = 0;
      push_grant(11, 1, 0, 0);
      push_grant(3, 1, 0, 0);
      push_ev(0, 0, 1, 0, 0);
      send(11, 1, 3, 1, 0);
      for (int c = 1; c <= 4; c++) begin
         @(negedge clk);
         check($sformatf("t1_in_ready_c%0d", c), in_ready, (c == 4) ? 1 : 0);
      end
      drain("t1", 20);

      // Single grant, ack delayed by 3 cycles
      ack_wait = 3;
      push_grant(5, 4, 0, 0);
      push_ev(0, 0, 1, 0, 0);
      send(5, 1, 0, 0, 0);
      drain("t2", 30);

      // Ack in the last counted cycle: no timeout
      ack_wait = TIMEOUT - 1;
      push_grant(9, TIMEOUT, 0, 0);
      push_ev(0, 0, 1, 0, 0);
      send(9, 1, 0, 0, 0);
      drain("ack_last", 60);

      // Both grants time out
      ack_wait = -1;
      push_grant(7, TIMEOUT, 0, 0);
      push_grant(2, TIMEOUT, 1, 0);
      push_ev(0, 0, 1, 1, 0);
      send(7, 1, 2, 1, 0);
      drain("timeout", 100);

      // Malformed pairs
      ack_wait = 0;
      push_ev(0, 0, 0, 0, 1);
      push_ev(0, 0, 1, 0, 0);
      send(12, 1, 4, 1, 0);
      drain("bad_first", 20);

      push_grant(4, 1, 0, 1);
      push_ev(0, 0, 1, 0, 0);
      send(4, 1, 9, 1, 0);
      drain("second_above_first", 20);

      push_grant(5, 1, 0, 1);
      push_ev(0, 0, 1, 0, 0);
      send(5, 1, 5, 1, 0);
      drain("second_eq_first", 20);

      push_ev(0, 0, 0, 0, 1);
      push_ev(0, 0, 1, 0, 0);
      send(0, 0, 3, 1, 0);
      drain("second_only", 20);

      // in_valid held high across three pairs
      push_grant(10, 1, 0, 0);
      push_grant(6, 1, 0, 0);
      push_ev(0, 0, 1, 0, 0);
      send(10, 1, 6, 1, 1);
      push_grant(8, 1, 0, 0);
      push_ev(0, 0, 1, 0, 0);
      send(8, 1, 0, 0, 1);
      push_grant(3, 1, 0, 0);
      push_grant(1, 1, 0, 0);
      push_ev(0, 0, 1, 0, 0);
      send(3, 1, 1, 1, 0);
      drain("held_valid", 40);

      // Reset in the third G2 cycle, then a normal pair
      ack_wait = -1;
      push_grant(5, TIMEOUT, 0, 0);
      push_grant(2, 3, 1, 0);
      send(5, 1, 2, 1, 0);
      repeat (TIMEOUT + 3) @(negedge clk);
      #1;
      reset_n = 1'b0;
      #1;
      check("rst_mid_gnt", gnt, 0);
      check("rst_mid_gnt_idx", gnt_idx, 0);
      check("rst_mid_in_ready", in_ready, 1);
      check("rst_mid_consumed", exp_q.size(), 0);
      exp_q.delete();
      repeat (2) @(negedge clk);
      reset_n  = 1'b1;
      ack_wait = 0;
      @(negedge clk);
      check("post_rst_in_ready", in_ready, 1);
      push_grant(6, 1, 0, 0);
      push_grant(0, 1, 0, 0);
      push_ev(0, 0, 1, 0, 0);
      send(6, 1, 0, 1, 0);
      drain("post_rst", 20);

      repeat (3) @(negedge clk);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
